ahb_master_arb: RTL and testbench
=================================

Name: ahb_master_arb

Overview:
- Two-master AHB-Lite arbiter sharing the core's single system bus between the memory access unit (m0, MAU load/store port) and the instruction fetch unit (m1).
- Sits between the two masters and the bus. Multiplexes the address and control phase and the write-data phase.
- Returns per-master hready, hrdata and hresp. Buffers the data-phase response of a master whose next address is denied.
- Fixed priority favours m0. A starvation counter guarantees m1 progress. Locked and burst sequences are never split.

Parameters:
STARVE_LIMIT, 8, consecutive denied m1 arbitration cycles before m1 gets one forced grant
CNT_W, 4, starvation counter width; must hold STARVE_LIMIT

Ports:
hclk  in  1  system clock
hrstn  in  1  asynchronous active-low reset
m0_haddr/m1_haddr  in  32  master address
m0_htrans/m1_htrans  in  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
m0_hwrite/m1_hwrite  in  1  master write
m0_hsize/m1_hsize  in  3  master size
m0_hburst/m1_hburst  in  3  master burst
m0_hprot/m1_hprot  in  7  master protection
m0_hmastlock/m1_hmastlock  in  1  master lock
m0_hwdata/m1_hwdata  in  32  master write data
m0_hready/m1_hready  out  1  per-master ready
m0_hrdata/m1_hrdata  out  32  per-master read data
m0_hresp/m1_hresp  out  1  per-master response
hready  in  1  bus ready
hresp  in  1  bus response
hrdata  in  32  bus read data
haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock  out  32,2,1,3,3,7,1  bus address and control
hwdata  out  32  bus write data
gnt  out  1  current address-phase owner (0=m0, 1=m1)

Behaviour:
- reqN = (mN_htrans != IDLE). newN = (mN_htrans == NONSEQ).
- Registered state, all cleared on hrstn low, asynchronously:
  - last_owner = 0
  - dph_act = 0, dph_own = 0
  - starve_cnt = 0
  - pend0 = pend1 = 0
  - buffer registers = 0
- Grant is combinational, evaluated every cycle, in priority order:
  - (a) last_owner's hmastlock = 1, or last_owner's htrans is SEQ/BUSY -> gnt = last_owner.
  - (b) else starve_cnt == STARVE_LIMIT and req1 -> gnt = 1.
  - (c) else new0 or req0 -> 0.
  - (d) else req1 -> 1.
  - (e) else gnt = last_owner (parking).
- Bus address and control outputs are a pure mux of the gnt master, including htrans. There is no register stage, so address phase latency is 0.
- On a cycle with hready = 1:
  - last_owner <= gnt
  - dph_act <= (selected htrans is NONSEQ or SEQ)
  - dph_own <= gnt
- hwdata = dph_own ? m1_hwdata : m0_hwdata.
- waitN = reqN & (gnt != N).
- mN_hready = hready & ~waitN.
- Response capture:
  - When hready = 1, dph_act = 1, dph_own = N and waitN = 1, the bus completes N's data phase but N's next address is refused.
  - On that cycle: pendN <= 1, bufN_rdata <= hrdata, bufN_resp <= hresp.
- mN_hrdata/mN_hresp = pendN ? buffered values : bus hrdata/hresp.
- pendN clears on any cycle with mN_hready = 1. Capture and clear in the same cycle cannot occur.
- Starvation counter, updated on hready = 1 cycles only; hready = 0 freezes it:
  - req1 & gnt == 0 -> starve_cnt increments, saturating at STARVE_LIMIT.
  - gnt == 1 -> starve_cnt clears to 0.
- Locked or burst hold overrides starvation; the counter keeps saturating during the hold.
- An IDLE master with nothing outstanding sees bus hready and hrdata directly.
- An error response (hresp = 1) passes through or is buffered like data. The arbiter adds no two-cycle error handling of its own.
- Reset mid-transfer: all state returns to reset values immediately. Bus outputs then follow m0's inputs, since gnt = 0.

Test Plan:
- Reset, then m0 NONSEQ read 0x1000 with hrdata = 0xDEADBEEF -> gnt = 0, haddr = 0x1000 in cycle 0; m0_hready = 1 and m0_hrdata = 0xDEADBEEF in cycle 1; m1_hready follows bus hready.
- m0 and m1 both issue NONSEQ the same cycle, repeatedly, STARVE_LIMIT = 8 -> m0 is granted 8 consecutive transfers. The 9th grant goes to m1. starve_cnt returns to 0, then m0 wins again.
- m1 running a 4-beat INCR4 from 0x2000 (SEQ beats) while m0 requests -> haddr sequence 0x2000, 0x2004, 0x2008, 0x200C all from m1. m0 is granted in the first cycle after the last SEQ beat, and m0_hready = 0 until then.
- m1 read of 0x3000 completes (hrdata = 0x12345678) while m1 issues NONSEQ 0x3004 and m0 wins -> pend1 = 1 and m1_hready held 0. When m1 is granted, m1_hready = 1 and m1_hrdata = 0x12345678 (buffered), then pend1 = 0.
- m0 write 0x4000 with hmastlock = 1 followed by a locked write, while m1 requests -> no m1 grant until m0 drops hmastlock. hwdata tracks m0_hwdata in each data phase.
- hready held 0 for 3 cycles during an m0 data phase -> last_owner, dph_* and starve_cnt are unchanged. Asserting hrstn = 0 mid-stall clears pend0/pend1 and starve_cnt to 0 asynchronously and sets gnt = 0.

Source files
------------

// File: rtl/ahb_master_arb_if.sv
// ahb_master_arb_if: the two AHB-Lite master ports and the shared system bus
// seen by the two-master arbiter.
interface ahb_master_arb_if;
    logic [31:0] m0_haddr;
    logic [1:0]  m0_htrans;
    logic        m0_hwrite;
    logic [2:0]  m0_hsize;
    logic [2:0]  m0_hburst;
    logic [6:0]  m0_hprot;
    logic        m0_hmastlock;
    logic [31:0] m0_hwdata;
    logic        m0_hready;
    logic [31:0] m0_hrdata;
    logic        m0_hresp;

    logic [31:0] m1_haddr;
    logic [1:0]  m1_htrans;
    logic        m1_hwrite;
    logic [2:0]  m1_hsize;
    logic [2:0]  m1_hburst;
    logic [6:0]  m1_hprot;
    logic        m1_hmastlock;
    logic [31:0] m1_hwdata;
    logic        m1_hready;
    logic [31:0] m1_hrdata;
    logic        m1_hresp;

    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [6:0]  hprot;
    logic        hmastlock;
    logic [31:0] hwdata;
    logic        gnt;

    modport slave (
        input  m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst,
        input  m0_hprot, m0_hmastlock, m0_hwdata,
        input  m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst,
        input  m1_hprot, m1_hmastlock, m1_hwdata,
        input  hready, hresp, hrdata,
        output m0_hready, m0_hrdata, m0_hresp,
        output m1_hready, m1_hrdata, m1_hresp,
        output haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        output hwdata, gnt
    );

    modport master (
        output m0_haddr, m0_htrans, m0_hwrite, m0_hsize, m0_hburst,
        output m0_hprot, m0_hmastlock, m0_hwdata,
        output m1_haddr, m1_htrans, m1_hwrite, m1_hsize, m1_hburst,
        output m1_hprot, m1_hmastlock, m1_hwdata,
        output hready, hresp, hrdata,
        input  m0_hready, m0_hrdata, m0_hresp,
        input  m1_hready, m1_hrdata, m1_hresp,
        input  haddr, htrans, hwrite, hsize, hburst, hprot, hmastlock,
        input  hwdata, gnt
    );
endinterface

// File: rtl/ahb_master_arb.sv
// ahb_master_arb: two-master AHB-Lite arbiter, m0 (MAU) fixed priority,
// m1 (IFU) starvation guard, lock/burst holds, refused-master response buffer.
module ahb_master_arb #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input logic             hclk,
    input logic             hrstn,
    ahb_master_arb_if.slave bus
);
    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_BUSY   = 2'd1;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    logic             last_owner;
    logic             dph_act;
    logic             dph_own;
    logic [CNT_W-1:0] starve_cnt;
    logic             pend0;
    logic             pend1;
    logic [31:0]      buf0_rdata;
    logic [31:0]      buf1_rdata;
    logic             buf0_resp;
    logic             buf1_resp;

    logic       req0;
    logic       req1;
    logic       new0;
    logic       own_lock;
    logic [1:0] own_trans;
    logic       hold;
    logic       starved;
    logic       gnt_c;
    logic [1:0] sel_trans;
    logic       wait0;
    logic       wait1;
    logic       rdy0;
    logic       rdy1;
    logic       cap0;
    logic       cap1;

    assign req0 = (bus.m0_htrans != TR_IDLE);
    assign req1 = (bus.m1_htrans != TR_IDLE);
    assign new0 = (bus.m0_htrans == TR_NONSEQ);

    // A locked owner or one mid-burst keeps the bus, even over starvation.
    assign own_lock  = last_owner ? bus.m1_hmastlock : bus.m0_hmastlock;
    assign own_trans = last_owner ? bus.m1_htrans : bus.m0_htrans;
    assign hold      = own_lock
                     | (own_trans == TR_SEQ)
                     | (own_trans == TR_BUSY);
    assign starved   = (starve_cnt == CNT_MAX) & req1;

    always_comb begin
        gnt_c = last_owner;
        priority case (1'b1)
            hold:          gnt_c = last_owner;
            starved:       gnt_c = 1'b1;
            new0 | req0:   gnt_c = 1'b0;
            req1:          gnt_c = 1'b1;
            default:       gnt_c = last_owner;
        endcase
    end

    assign sel_trans     = gnt_c ? bus.m1_htrans : bus.m0_htrans;

    assign bus.gnt       = gnt_c;
    assign bus.haddr     = gnt_c ? bus.m1_haddr     : bus.m0_haddr;
    assign bus.htrans    = sel_trans;
    assign bus.hwrite    = gnt_c ? bus.m1_hwrite    : bus.m0_hwrite;
    assign bus.hsize     = gnt_c ? bus.m1_hsize     : bus.m0_hsize;
    assign bus.hburst    = gnt_c ? bus.m1_hburst    : bus.m0_hburst;
    assign bus.hprot     = gnt_c ? bus.m1_hprot     : bus.m0_hprot;
    assign bus.hmastlock = gnt_c ? bus.m1_hmastlock : bus.m0_hmastlock;
    assign bus.hwdata    = dph_own ? bus.m1_hwdata  : bus.m0_hwdata;

    assign wait0 = req0 & gnt_c;
    assign wait1 = req1 & ~gnt_c;
    assign rdy0  = bus.hready & ~wait0;
    assign rdy1  = bus.hready & ~wait1;

    // Data phase finishing for a master whose next address lost arbitration.
    assign cap0 = bus.hready & dph_act & ~dph_own & wait0;
    assign cap1 = bus.hready & dph_act &  dph_own & wait1;

    assign bus.m0_hready = rdy0;
    assign bus.m1_hready = rdy1;
    assign bus.m0_hrdata = pend0 ? buf0_rdata : bus.hrdata;
    assign bus.m1_hrdata = pend1 ? buf1_rdata : bus.hrdata;
    assign bus.m0_hresp  = pend0 ? buf0_resp  : bus.hresp;
    assign bus.m1_hresp  = pend1 ? buf1_resp  : bus.hresp;

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            last_owner <= 1'b0;
            dph_act    <= 1'b0;
            dph_own    <= 1'b0;
        end else if (bus.hready) begin
            last_owner <= gnt_c;
            dph_act    <= (sel_trans == TR_NONSEQ) | (sel_trans == TR_SEQ);
            dph_own    <= gnt_c;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            starve_cnt <= '0;
        end else if (bus.hready) begin
            if (gnt_c) begin
                starve_cnt <= '0;
            end else if (req1 && starve_cnt != CNT_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            pend0      <= 1'b0;
            buf0_rdata <= '0;
            buf0_resp  <= 1'b0;
        end else if (cap0) begin
            pend0      <= 1'b1;
            buf0_rdata <= bus.hrdata;
            buf0_resp  <= bus.hresp;
        end else if (rdy0) begin
            pend0      <= 1'b0;
        end
    end

    always_ff @(posedge hclk or negedge hrstn) begin
        if (!hrstn) begin
            pend1      <= 1'b0;
            buf1_rdata <= '0;
            buf1_resp  <= 1'b0;
        end else if (cap1) begin
            pend1      <= 1'b1;
            buf1_rdata <= bus.hrdata;
            buf1_resp  <= bus.hresp;
        end else if (rdy1) begin
            pend1      <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ahb_master_arb.sv
// tb_ahb_master_arb: directed stimulus for the two-master arbiter, checked
// every cycle against a behavioural model plus hand-computed expectations.
module tb_ahb_master_arb;
    localparam int LIMIT = 8;
    localparam logic [1:0] IDLE = 2'd0, NSQ = 2'd2, SEQ = 2'd3;

    logic hclk = 1'b0;
    logic hrstn = 1'b0;
    always #5 hclk = ~hclk;

    ahb_master_arb_if bus();

    ahb_master_arb #(.STARVE_LIMIT(LIMIT), .CNT_W(4)) dut (
        .hclk (hclk),
        .hrstn(hrstn),
        .bus  (bus)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Model state: who holds the bus, which master's data phase is live,
    // how long m1 has been refused, and responses owed to refused masters.
    int          m_owner = 0;
    int          m_dph_who = 0;
    bit          m_dph_valid = 0;
    int          m_denied = 0;
    bit          m_owed[2] = '{0, 0};
    logic [31:0] m_buf_rd[2] = '{0, 0};
    logic        m_buf_rs[2] = '{0, 0};

    function automatic logic [1:0] trans_of(int n);
        return (n != 0) ? bus.m1_htrans : bus.m0_htrans;
    endfunction

    function automatic logic lock_of(int n);
        return (n != 0) ? bus.m1_hmastlock : bus.m0_hmastlock;
    endfunction

    function automatic int exp_gnt();
        if (lock_of(m_owner) || trans_of(m_owner) inside {2'd1, 2'd3})
            return m_owner;
        if (m_denied >= LIMIT && trans_of(1) != IDLE) return 1;
        if (trans_of(0) != IDLE) return 0;
        if (trans_of(1) != IDLE) return 1;
        return m_owner;
    endfunction

    function automatic bit refused(int n, int g);
        return trans_of(n) != IDLE && g != n;
    endfunction

    always @(posedge hclk or negedge hrstn) begin : mdl
        int g;
        bit w[2];
        if (!hrstn) begin
            m_owner = 0; m_dph_who = 0; m_dph_valid = 0; m_denied = 0;
            m_owed = '{0, 0}; m_buf_rd = '{0, 0}; m_buf_rs = '{0, 0};
        end else begin
            g = exp_gnt();
            w[0] = refused(0, g);
            w[1] = refused(1, g);
            for (int n = 0; n < 2; n++) begin
                if (bus.hready && m_dph_valid && m_dph_who == n && w[n]) begin
                    m_owed[n] = 1;
                    m_buf_rd[n] = bus.hrdata;
                    m_buf_rs[n] = bus.hresp;
                end else if (bus.hready && !w[n]) begin
                    m_owed[n] = 0;
                end
            end
            if (bus.hready) begin
                if (g == 1) m_denied = 0;
                else if (trans_of(1) != IDLE) m_denied++;
                m_dph_valid = trans_of(g) >= 2'd2;
                m_dph_who = g;
                m_owner = g;
            end
        end
    end

    always @(negedge hclk) begin : cmp
        int g;
        g = exp_gnt();
        check("gnt", bus.gnt, g);
        check("haddr", bus.haddr, g ? bus.m1_haddr : bus.m0_haddr);
        check("htrans", bus.htrans, g ? bus.m1_htrans : bus.m0_htrans);
        check("hwrite", bus.hwrite, g ? bus.m1_hwrite : bus.m0_hwrite);
        check("hsize", bus.hsize, g ? bus.m1_hsize : bus.m0_hsize);
        check("hburst", bus.hburst, g ? bus.m1_hburst : bus.m0_hburst);
        check("hprot", bus.hprot, g ? bus.m1_hprot : bus.m0_hprot);
        check("hmastlock", bus.hmastlock,
              g ? bus.m1_hmastlock : bus.m0_hmastlock);
        check("hwdata", bus.hwdata,
              m_dph_who ? bus.m1_hwdata : bus.m0_hwdata);
        check("m0_hready", bus.m0_hready, bus.hready && !refused(0, g));
        check("m1_hready", bus.m1_hready, bus.hready && !refused(1, g));
        check("m0_hrdata", bus.m0_hrdata, m_owed[0] ? m_buf_rd[0] : bus.hrdata);
        check("m1_hrdata", bus.m1_hrdata, m_owed[1] ? m_buf_rd[1] : bus.hrdata);
        check("m0_hresp", bus.m0_hresp, m_owed[0] ? m_buf_rs[0] : bus.hresp);
        check("m1_hresp", bus.m1_hresp, m_owed[1] ? m_buf_rs[1] : bus.hresp);
        check("starve_cnt", dut.starve_cnt, (m_denied > LIMIT) ? LIMIT : m_denied);
    end

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic drv0(logic [1:0] tr, logic [31:0] a, logic wr = 0,
                        logic lk = 0, logic [2:0] bu = 0);
        bus.m0_htrans = tr; bus.m0_haddr = a; bus.m0_hwrite = wr;
        bus.m0_hmastlock = lk; bus.m0_hburst = bu;
    endtask

    task automatic drv1(logic [1:0] tr, logic [31:0] a, logic wr = 0,
                        logic lk = 0, logic [2:0] bu = 0);
        bus.m1_htrans = tr; bus.m1_haddr = a; bus.m1_hwrite = wr;
        bus.m1_hmastlock = lk; bus.m1_hburst = bu;
    endtask

    int grants[10];

    initial begin
        drv0(IDLE, 0); drv1(IDLE, 0);
        bus.m0_hsize = 3'd2; bus.m1_hsize = 3'd2;
        bus.m0_hprot = 7'h03; bus.m1_hprot = 7'h02;
        bus.m0_hwdata = 0; bus.m1_hwdata = 32'h0F0F0F0F;
        bus.hready = 1; bus.hresp = 0; bus.hrdata = 0;
        hrstn = 0;
        repeat (2) tick();

        // Reset state and a single m0 read
        check("rst_gnt", bus.gnt, 0);
        check("rst_pend0", dut.pend0, 0);
        check("rst_pend1", dut.pend1, 0);
        hrstn = 1;
        drv0(NSQ, 32'h1000);
        #1;
        check("t1_gnt", bus.gnt, 0);
        check("t1_haddr", bus.haddr, 32'h1000);
        check("t1_htrans", bus.htrans, NSQ);
        tick();
        drv0(IDLE, 0);
        bus.hrdata = 32'hDEADBEEF;
        #1;
        check("t1_m0_hready", bus.m0_hready, 1);
        check("t1_m0_hrdata", bus.m0_hrdata, 32'hDEADBEEF);
        check("t1_m1_hready", bus.m1_hready, 1);
        tick();
        bus.hready = 0;
        #1;
        check("t1_m1_hready_low", bus.m1_hready, 0);
        tick();
        bus.hready = 1;
        tick();

        // Both masters request every cycle: starvation forces one m1 grant
        for (int i = 0; i < 10; i++) begin
            drv0(NSQ, 32'h100 + 32'(4 * i));
            drv1(NSQ, 32'h200);
            #1;
            grants[i] = bus.gnt;
            if (i == 9) check("t2_cnt_cleared", dut.starve_cnt, 0);
            tick();
        end
        for (int i = 0; i < 8; i++) check("t2_m0_run", grants[i], 0);
        check("t2_forced_m1", grants[8], 1);
        check("t2_m0_again", grants[9], 0);
        drv0(IDLE, 0); drv1(IDLE, 0);
        repeat (2) tick();

        // m1 INCR4 burst is not split by an m0 request
        drv1(NSQ, 32'h2000, 0, 0, 3'd3);
        #1;
        check("t3_gnt_a", bus.gnt, 1);
        check("t3_haddr_a", bus.haddr, 32'h2000);
        tick();
        for (int k = 1; k < 4; k++) begin
            drv1(SEQ, 32'h2000 + 32'(4 * k), 0, 0, 3'd3);
            drv0(NSQ, 32'h5000);
            #1;
            check("t3_gnt_seq", bus.gnt, 1);
            check("t3_haddr_seq", bus.haddr, 32'h2000 + 32'(4 * k));
            check("t3_m0_wait", bus.m0_hready, 0);
            tick();
        end
        drv1(IDLE, 0);
        #1;
        check("t3_gnt_e", bus.gnt, 0);
        check("t3_haddr_e", bus.haddr, 32'h5000);
        check("t3_m0_rdy", bus.m0_hready, 1);
        tick();
        drv0(IDLE, 0);
        tick();

        // m1 refused after its read completes: response is buffered
        drv1(NSQ, 32'h3000);
        #1;
        check("t4_gnt_a", bus.gnt, 1);
        tick();
        bus.hrdata = 32'h12345678; bus.hresp = 1;
        drv1(NSQ, 32'h3004);
        drv0(NSQ, 32'h6000);
        #1;
        check("t4_gnt_b", bus.gnt, 0);
        check("t4_m1_wait", bus.m1_hready, 0);
        tick();
        bus.hrdata = 32'hAAAA0000; bus.hresp = 0;
        drv0(IDLE, 0);
        #1;
        check("t4_gnt_c", bus.gnt, 1);
        check("t4_m1_rdy", bus.m1_hready, 1);
        check("t4_m1_buf", bus.m1_hrdata, 32'h12345678);
        check("t4_m1_bresp", bus.m1_hresp, 1);
        check("t4_m0_rd", bus.m0_hrdata, 32'hAAAA0000);
        tick();
        drv1(IDLE, 0);
        bus.hrdata = 32'h00000055;
        #1;
        check("t4_m1_live", bus.m1_hrdata, 32'h00000055);
        check("t4_pend1_clr", dut.pend1, 0);
        tick();

        // Locked m0 writes hold the bus past the starvation limit
        for (int i = 0; i < 10; i++) begin
            drv0(NSQ, 32'h4000 + 32'(4 * i), 1, 1);
            bus.m0_hwdata = 32'h11110000 + 32'(i);
            drv1(NSQ, 32'h7000);
            #1;
            check("t5_lock_gnt", bus.gnt, 0);
            if (i > 0) check("t5_hwdata", bus.hwdata, 32'h11110000 + 32'(i));
            tick();
        end
        drv0(IDLE, 0, 0, 0);
        bus.m0_hwdata = 32'h1111000A;
        #1;
        check("t5_unlock_gnt", bus.gnt, 1);
        check("t5_hwdata_last", bus.hwdata, 32'h1111000A);
        tick();
        drv1(IDLE, 0);
        tick();

        // Stall with a buffered m1 response, then reset mid-stall
        drv1(NSQ, 32'hA000);
        tick();
        bus.hrdata = 32'hBBBB0001;
        drv1(NSQ, 32'hA004);
        drv0(NSQ, 32'h8000);
        #1;
        check("t6_gnt_b", bus.gnt, 0);
        tick();
        bus.hready = 0;
        bus.hrdata = 32'hCCCC0002;
        drv0(NSQ, 32'h8004);
        for (int s = 0; s < 3; s++) begin
            #1;
            check("t6_last_owner", dut.last_owner, 0);
            check("t6_dph_act", dut.dph_act, 1);
            check("t6_dph_own", dut.dph_own, 0);
            check("t6_starve", dut.starve_cnt, 1);
            check("t6_m1_buf", bus.m1_hrdata, 32'hBBBB0001);
            if (s < 2) tick();
        end
        #1;
        hrstn = 0;
        #1;
        check("t6_rst_pend1", dut.pend1, 0);
        check("t6_rst_pend0", dut.pend0, 0);
        check("t6_rst_starve", dut.starve_cnt, 0);
        check("t6_rst_gnt", bus.gnt, 0);
        check("t6_rst_haddr", bus.haddr, 32'h8004);
        check("t6_rst_m1_rd", bus.m1_hrdata, 32'hCCCC0002);
        tick();
        hrstn = 1;
        bus.hready = 1;
        drv0(IDLE, 0); drv1(IDLE, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
